// File: rtl/toy_bus_arb_node_nch.sv
// N-input round-robin bus arbitration node with a registered request stage and
// an in-order grant tracker for ack routing. Optional debug: TOY_BUS_ARB_NODE_ERR_EN.
module toy_bus_arb_node_nch #(
  parameter int NUM_IN    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int STRB_W    = 32,
  parameter int ID_W      = 4,
  parameter int SB_W      = 10,
  parameter int OST_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        in_req_vld,
  output logic [NUM_IN-1:0]        in_req_rdy,
  input  logic [NUM_IN*ADDR_W-1:0] in_req_addr,
  input  logic [NUM_IN*STRB_W-1:0] in_req_strb,
  input  logic [NUM_IN*DATA_W-1:0] in_req_data,
  input  logic [NUM_IN-1:0]        in_req_opcode,
  input  logic [NUM_IN*ID_W-1:0]   in_req_src_id,
  input  logic [NUM_IN*ID_W-1:0]   in_req_tgt_id,
  input  logic [NUM_IN*SB_W-1:0]   in_req_sideband,
  output logic                     out_req_vld,
  input  logic                     out_req_rdy,
  output logic [ADDR_W-1:0]        out_req_addr,
  output logic [STRB_W-1:0]        out_req_strb,
  output logic [DATA_W-1:0]        out_req_data,
  output logic                     out_req_opcode,
  output logic [ID_W-1:0]          out_req_src_id,
  output logic [ID_W-1:0]          out_req_tgt_id,
  output logic [SB_W-1:0]          out_req_sideband,
  input  logic                     out_ack_vld,
  output logic                     out_ack_rdy,
  input  logic                     out_ack_opcode,
  input  logic [DATA_W-1:0]        out_ack_data,
  input  logic [SB_W-1:0]          out_ack_sideband,
  input  logic [ID_W-1:0]          out_ack_src_id,
  input  logic [ID_W-1:0]          out_ack_tgt_id,
  output logic [NUM_IN-1:0]        in_ack_vld,
  input  logic [NUM_IN-1:0]        in_ack_rdy,
  output logic [NUM_IN-1:0]        in_ack_opcode,
  output logic [NUM_IN*DATA_W-1:0] in_ack_data,
  output logic [NUM_IN*SB_W-1:0]   in_ack_sideband,
  output logic [NUM_IN*ID_W-1:0]   in_ack_src_id,
  output logic [NUM_IN*ID_W-1:0]   in_ack_tgt_id
`ifdef TOY_BUS_ARB_NODE_ERR_EN
  ,
  output logic                     err_unexp_ack,
  output logic [$clog2(NUM_IN)-1:0] err_ack_chan
`endif
);

  localparam int CH_W  = $clog2(NUM_IN);
  localparam int PTR_W = $clog2(OST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = OST_DEPTH[CNT_W-1:0];
  localparam logic [CH_W-1:0]  LAST = CH_W'(NUM_IN - 1);

  logic [CH_W-1:0]  rr_ptr_reg;
  logic [CH_W-1:0]  winner;
  logic             found;
  logic             load_ok;
  logic             grant_en;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CH_W-1:0]  trk_mem [OST_DEPTH];
  logic [CH_W-1:0]  head;
  logic             trk_empty;
  logic             push, pop;

  // Search starts at rr_ptr so the last winner becomes lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      int idx;
      idx = (int'(rr_ptr_reg) + k) % NUM_IN;
      if (!found && in_req_vld[idx]) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

  assign load_ok   = !out_req_vld || out_req_rdy;
  // Full blocks grants even if an ack pops this cycle; keeps the grant path off the ack path.
  assign grant_en  = load_ok && (count_reg != FULL) && found;
  assign trk_empty = (count_reg == '0);
  assign head      = trk_mem[rd_ptr_reg];
  assign push      = grant_en;
  assign pop       = out_ack_vld && out_ack_rdy && !trk_empty;
  assign out_ack_rdy = trk_empty ? 1'b1 : in_ack_rdy[head];

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
    assign in_req_rdy[gi] = grant_en && (winner == CH_W'(gi));
    assign in_ack_vld[gi] = out_ack_vld && !trk_empty && (head == CH_W'(gi));
    assign in_ack_opcode[gi]                    = out_ack_opcode;
    assign in_ack_data[gi*DATA_W +: DATA_W]     = out_ack_data;
    assign in_ack_sideband[gi*SB_W +: SB_W]     = out_ack_sideband;
    assign in_ack_src_id[gi*ID_W +: ID_W]       = out_ack_src_id;
    assign in_ack_tgt_id[gi*ID_W +: ID_W]       = out_ack_tgt_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg       <= '0;
      out_req_vld      <= 1'b0;
      out_req_addr     <= '0;
      out_req_strb     <= '0;
      out_req_data     <= '0;
      out_req_opcode   <= 1'b0;
      out_req_src_id   <= '0;
      out_req_tgt_id   <= '0;
      out_req_sideband <= '0;
    end else begin
      if (grant_en)
        rr_ptr_reg <= (winner == LAST) ? '0 : winner + 1'b1;
      if (load_ok) begin
        out_req_vld <= grant_en;
        if (grant_en) begin
          out_req_addr     <= in_req_addr[int'(winner)*ADDR_W +: ADDR_W];
          out_req_strb     <= in_req_strb[int'(winner)*STRB_W +: STRB_W];
          out_req_data     <= in_req_data[int'(winner)*DATA_W +: DATA_W];
          out_req_opcode   <= in_req_opcode[winner];
          out_req_src_id   <= in_req_src_id[int'(winner)*ID_W +: ID_W];
          out_req_tgt_id   <= in_req_tgt_id[int'(winner)*ID_W +: ID_W];
          out_req_sideband <= in_req_sideband[int'(winner)*SB_W +: SB_W];
        end
      end
    end
  end

  // Tracker storage needs no reset: entries are only read when count != 0.
  always_ff @(posedge clk) begin
    if (push)
      trk_mem[wr_ptr_reg] <= winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
    end
  end

`ifdef TOY_BUS_ARB_NODE_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unexp_ack <= 1'b0;
      err_ack_chan  <= '0;
    end else begin
      if (out_ack_vld && trk_empty)
        err_unexp_ack <= 1'b1;
      if (pop)
        err_ack_chan <= head;
    end
  end
`endif

endmodule

// File: tb/tb_toy_bus_arb_node_nch.sv
// Directed bench for toy_bus_arb_node_nch (NUM_IN=4, OST_DEPTH=4, narrow data).
module tb_toy_bus_arb_node_nch;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 4;
  localparam int BW = 10;
  localparam int OD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    in_req_vld = '0;
  logic [N-1:0]    in_req_rdy;
  logic [N*AW-1:0] in_req_addr = '0;
  logic [N*SW-1:0] in_req_strb = '0;
  logic [N*DW-1:0] in_req_data = '0;
  logic [N-1:0]    in_req_opcode = '0;
  logic [N*IW-1:0] in_req_src_id = '0;
  logic [N*IW-1:0] in_req_tgt_id = '0;
  logic [N*BW-1:0] in_req_sideband = '0;
  logic            out_req_vld;
  logic            out_req_rdy = 1'b1;
  logic [AW-1:0]   out_req_addr;
  logic [SW-1:0]   out_req_strb;
  logic [DW-1:0]   out_req_data;
  logic            out_req_opcode;
  logic [IW-1:0]   out_req_src_id;
  logic [IW-1:0]   out_req_tgt_id;
  logic [BW-1:0]   out_req_sideband;
  logic            out_ack_vld = 1'b0;
  logic            out_ack_rdy;
  logic            out_ack_opcode = 1'b0;
  logic [DW-1:0]   out_ack_data = '0;
  logic [BW-1:0]   out_ack_sideband = '0;
  logic [IW-1:0]   out_ack_src_id = '0;
  logic [IW-1:0]   out_ack_tgt_id = '0;
  logic [N-1:0]    in_ack_vld;
  logic [N-1:0]    in_ack_rdy = '1;
  logic [N-1:0]    in_ack_opcode;
  logic [N*DW-1:0] in_ack_data;
  logic [N*BW-1:0] in_ack_sideband;
  logic [N*IW-1:0] in_ack_src_id;
  logic [N*IW-1:0] in_ack_tgt_id;
`ifdef TOY_BUS_ARB_NODE_ERR_EN
  logic            err_unexp_ack;
  logic [1:0]      err_ack_chan;
`endif

  int n_cmp = 0;
  int n_err = 0;

  toy_bus_arb_node_nch #(
    .NUM_IN(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW),
    .ID_W(IW), .SB_W(BW), .OST_DEPTH(OD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy),
    .in_req_addr(in_req_addr), .in_req_strb(in_req_strb),
    .in_req_data(in_req_data), .in_req_opcode(in_req_opcode),
    .in_req_src_id(in_req_src_id), .in_req_tgt_id(in_req_tgt_id),
    .in_req_sideband(in_req_sideband),
    .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy),
    .out_req_addr(out_req_addr), .out_req_strb(out_req_strb),
    .out_req_data(out_req_data), .out_req_opcode(out_req_opcode),
    .out_req_src_id(out_req_src_id), .out_req_tgt_id(out_req_tgt_id),
    .out_req_sideband(out_req_sideband),
    .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy),
    .out_ack_opcode(out_ack_opcode), .out_ack_data(out_ack_data),
    .out_ack_sideband(out_ack_sideband), .out_ack_src_id(out_ack_src_id),
    .out_ack_tgt_id(out_ack_tgt_id),
    .in_ack_vld(in_ack_vld), .in_ack_rdy(in_ack_rdy),
    .in_ack_opcode(in_ack_opcode), .in_ack_data(in_ack_data),
    .in_ack_sideband(in_ack_sideband), .in_ack_src_id(in_ack_src_id),
    .in_ack_tgt_id(in_ack_tgt_id)
`ifdef TOY_BUS_ARB_NODE_ERR_EN
    , .err_unexp_ack(err_unexp_ack), .err_ack_chan(err_ack_chan)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are settled afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_chan(input int ch, input logic [31:0] addr, input logic [3:0] src);
    in_req_addr[ch*AW +: AW]   = addr;
    in_req_src_id[ch*IW +: IW] = src;
    in_req_data[ch*DW +: DW]   = 32'hD000_0000 | addr;
  endtask

  initial begin
    for (int c = 0; c < N; c++) set_chan(c, 32'h10 * c, 4'(c));

    // Reset state
    #2;
    chk("rst_out_vld", 64'(out_req_vld), 64'd0);
    chk("rst_out_addr", 64'(out_req_addr), 64'd0);
    chk("rst_ack_vld", 64'(in_ack_vld), 64'd0);
    chk("rst_ack_rdy_empty", 64'(out_ack_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Channel 2 alone: same-cycle ready, registered output next cycle
    set_chan(2, 32'h100, 4'h2);
    in_req_vld = 4'b0100;
    settle();
    chk("ch2_rdy", 64'(in_req_rdy), 64'b0100);
    tick();
    in_req_vld = 4'b0000;
    chk("ch2_out_vld", 64'(out_req_vld), 64'd1);
    chk("ch2_out_addr", 64'(out_req_addr), 64'h100);
    // rr_ptr now 3: with ch1 and ch3 valid, ch3 must win
    in_req_vld = 4'b1010;
    settle();
    chk("rr_after_ch2", 64'(in_req_rdy), 64'b1000);
    tick();
    in_req_vld = 4'b0000;
    chk("ch3_src", 64'(out_req_src_id), 64'd3);

    // Acks return in issue order: ch2 then ch3
    out_ack_vld = 1'b1;
    out_ack_data = 32'hA;
    settle();
    chk("ack0_vld", 64'(in_ack_vld), 64'b0100);
    chk("ack0_data", 64'(in_ack_data[2*DW +: DW]), 64'hA);
    tick();
    out_ack_data = 32'hB;
    in_ack_rdy = 4'b0111;
    settle();
    chk("ack1_vld", 64'(in_ack_vld), 64'b1000);
    chk("ack1_backpressure", 64'(out_ack_rdy), 64'd0);
    tick();
    chk("ack1_held", 64'(in_ack_vld), 64'b1000);
    in_ack_rdy = 4'b1111;
    settle();
    chk("ack1_rdy", 64'(out_ack_rdy), 64'd1);
    chk("ack1_data", 64'(in_ack_data[3*DW +: DW]), 64'hB);
    tick();
    out_ack_vld = 1'b0;
    for (int c = 0; c < N; c++) set_chan(c, 32'h10 * c, 4'(c));

    // Alternation ch0/ch1 from rr_ptr=0, full throughput, fills tracker
    in_req_vld = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("alt_rdy_%0d", k), 64'(in_req_rdy), (k % 2 == 0) ? 64'b0001 : 64'b0010);
      tick();
      chk($sformatf("alt_vld_%0d", k), 64'(out_req_vld), 64'd1);
      chk($sformatf("alt_src_%0d", k), 64'(out_req_src_id), 64'(k % 2));
    end
    settle();
    chk("full_rdy", 64'(in_req_rdy), 64'd0);
    tick();
    chk("full_out_drained", 64'(out_req_vld), 64'd0);
    chk("full_rdy_hold", 64'(in_req_rdy), 64'd0);

    // One ack while full: pop this cycle, grant only on the next
    out_ack_vld = 1'b1;
    out_ack_data = 32'h1;
    settle();
    chk("full_ack_vld", 64'(in_ack_vld), 64'b0001);
    chk("full_pop_no_grant", 64'(in_req_rdy), 64'd0);
    tick();
    out_ack_vld = 1'b0;
    settle();
    chk("resume_rdy", 64'(in_req_rdy), 64'b0001);
    tick();
    in_req_vld = 4'b0000;

    // Drain: issue order is now ch1, ch0, ch1, ch0
    out_ack_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      out_ack_data = 32'hA + 32'(k);
      settle();
      chk($sformatf("drain_vld_%0d", k), 64'(in_ack_vld), (k % 2 == 0) ? 64'b0010 : 64'b0001);
      chk($sformatf("drain_data_%0d", k), 64'(in_ack_data[((k % 2 == 0) ? 1 : 0)*DW +: DW]), 64'hA + 64'(k));
      tick();
    end
    out_ack_vld = 1'b0;
    settle();
    chk("drained_ack_vld", 64'(in_ack_vld), 64'd0);

    // Downstream stall: payload held, no grants, then same-cycle regrant
    set_chan(0, 32'h200, 4'h5);
    out_req_rdy = 1'b0;
    in_req_vld = 4'b0001;
    tick();
    set_chan(0, 32'h300, 4'h6);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_addr_%0d", k), 64'(out_req_addr), 64'h200);
      chk($sformatf("stall_rdy_%0d", k), 64'(in_req_rdy), 64'd0);
      tick();
    end
    out_req_rdy = 1'b1;
    settle();
    chk("unstall_rdy", 64'(in_req_rdy), 64'b0001);
    tick();
    in_req_vld = 4'b0000;
    chk("unstall_addr", 64'(out_req_addr), 64'h300);
    chk("unstall_vld", 64'(out_req_vld), 64'd1);
    tick();
    chk("unstall_idle", 64'(out_req_vld), 64'd0);
    out_ack_vld = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("stall_ack_%0d", k), 64'(in_ack_vld), 64'b0001);
      tick();
    end
    out_ack_vld = 1'b0;

    // Unexpected ack with empty tracker
    in_ack_rdy = 4'b0000;
    out_ack_vld = 1'b1;
    settle();
    chk("unexp_rdy", 64'(out_ack_rdy), 64'd1);
    chk("unexp_no_vld", 64'(in_ack_vld), 64'd0);
    tick();
    out_ack_vld = 1'b0;
    in_ack_rdy = 4'b1111;
`ifdef TOY_BUS_ARB_NODE_ERR_EN
    chk("err_sticky", 64'(err_unexp_ack), 64'd1);
    tick();
    chk("err_sticky_hold", 64'(err_unexp_ack), 64'd1);
`endif
    // Tracker untouched: a lone ack still reports empty
    out_ack_vld = 1'b1;
    settle();
    chk("unexp_still_empty", 64'(in_ack_vld), 64'd0);
    out_ack_vld = 1'b0;

    // Asynchronous reset mid-transfer
    in_req_vld = 4'b0100;
    tick();
    chk("pre_rst_vld", 64'(out_req_vld), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 64'(out_req_vld), 64'd0);
    chk("async_rst_addr", 64'(out_req_addr), 64'd0);
`ifdef TOY_BUS_ARB_NODE_ERR_EN
    chk("async_rst_err", 64'(err_unexp_ack), 64'd0);
`endif
    in_req_vld = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
